// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage and integer register file.
//
// Selects the writeback value from the MEM/WB register (load data or ALU
// result), commits it to a NREGS x XLEN register file, and serves two
// decode-stage read ports with same-cycle write-through bypass. Also
// exports the selected writeback value and effective write enable for the
// forwarding unit, and counts committed register writes.
//
// Ports:
//   clk               pipeline clock, rising-edge active
//   reset             asynchronous, active-high; clears registers and counter
//   mem_wb_read_data  load data from MEM/WB
//   mem_wb_result     ALU result from MEM/WB
//   mem_wb_rd         destination register index
//   mem_wb_memtoreg   1 = write load data, 0 = write ALU result
//   mem_wb_regwrite   write enable for this instruction
//   rs1, rs2          decode read addresses
//   readdata1/2       bypassed register values for rs1/rs2
//   wb_data           selected writeback value
//   wb_we             effective write enable (regwrite and rd != 0)
//   retire_count      committed register writes since reset (wraps silently)
//
// The address width is fixed at 5 bits; NREGS is expected to be 32.

module wb_regfile #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] mem_wb_read_data,
   input  logic [XLEN-1:0] mem_wb_result,
   input  logic [4:0]      mem_wb_rd,
   input  logic            mem_wb_memtoreg,
   input  logic            mem_wb_regwrite,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic [XLEN-1:0] readdata1,
   output logic [XLEN-1:0] readdata2,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_we,
   output logic [XLEN-1:0] retire_count
);

   logic [XLEN-1:0] regs [NREGS];

   always_comb begin
      wb_data = mem_wb_memtoreg ? mem_wb_read_data : mem_wb_result;
      // regwrite gates the rd compare, so an unknown rd with regwrite low
      // still yields a clean 0 here and cannot disturb state.
      wb_we   = mem_wb_regwrite && (mem_wb_rd != 5'd0);
   end

   // x0 reads as zero; otherwise a write in flight to the same register is
   // forwarded so decode sees it without waiting for the array update.
   function automatic logic [XLEN-1:0] read_port(input logic [4:0] rs);
      logic [XLEN-1:0] val;
      if (rs == 5'd0)
         val = '0;
      else if (wb_we && (mem_wb_rd == rs))
         val = wb_data;
      else
         val = regs[rs];
      return val;
   endfunction

   always_comb begin
      readdata1 = read_port(rs1);
      readdata2 = read_port(rs2);
   end

   // Reset has priority over any write, so a write pending while reset is
   // high is discarded. x0 is never written because wb_we excludes rd = 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
         retire_count <= '0;
      end else if (wb_we) begin
         regs[mem_wb_rd] <= wb_data;
         retire_count    <= retire_count + XLEN'(1);
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- self-checking bench for wb_regfile.
//
// A 64-bit instance runs a table of single-cycle vectors whose expected
// outputs are pushed to a scoreboard queue when driven and popped when the
// outputs settle, plus hand-written sequences for reset behaviour. An 8-bit
// instance exercises retire_count wrap-around.

module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        reset;

   logic [63:0] read_data, result;
   logic [4:0]  rd, rs1, rs2;
   logic        memtoreg, regwrite;
   logic [63:0] readdata1, readdata2, wb_data, retire_count;
   logic        wb_we;

   logic [7:0]  read_data_8, result_8;
   logic [4:0]  rd_8, rs1_8, rs2_8;
   logic        memtoreg_8, regwrite_8;
   logic [7:0]  readdata1_8, readdata2_8, wb_data_8, retire_count_8;
   logic        wb_we_8;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_regfile #(.XLEN(64), .NREGS(32)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .mem_wb_read_data (read_data),
      .mem_wb_result    (result),
      .mem_wb_rd        (rd),
      .mem_wb_memtoreg  (memtoreg),
      .mem_wb_regwrite  (regwrite),
      .rs1              (rs1),
      .rs2              (rs2),
      .readdata1        (readdata1),
      .readdata2        (readdata2),
      .wb_data          (wb_data),
      .wb_we            (wb_we),
      .retire_count     (retire_count)
   );

   wb_regfile #(.XLEN(8), .NREGS(32)) u_dut8 (
      .clk              (clk),
      .reset            (reset),
      .mem_wb_read_data (read_data_8),
      .mem_wb_result    (result_8),
      .mem_wb_rd        (rd_8),
      .mem_wb_memtoreg  (memtoreg_8),
      .mem_wb_regwrite  (regwrite_8),
      .rs1              (rs1_8),
      .rs2              (rs2_8),
      .readdata1        (readdata1_8),
      .readdata2        (readdata2_8),
      .wb_data          (wb_data_8),
      .wb_we            (wb_we_8),
      .retire_count     (retire_count_8)
   );

   typedef struct {
      logic        memtoreg;
      logic        regwrite;
      logic [4:0]  rd;
      logic [63:0] read_data;
      logic [63:0] result;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [63:0] exp_rd1;
      logic [63:0] exp_rd2;
      logic [63:0] exp_wb;
      logic        exp_we;
      logic [63:0] exp_cnt;
   } vec_t;

   typedef struct {
      logic [63:0] rd1;
      logic [63:0] rd2;
      logic [63:0] wb;
      logic        we;
      logic [63:0] cnt;
   } exp_t;

   vec_t vecs [9];
   exp_t sb [$];

   function automatic vec_t mk(input logic m2r, input logic rw, input logic [4:0] d,
                               input logic [63:0] ld, input logic [63:0] alu,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input logic [63:0] e1, input logic [63:0] e2,
                               input logic [63:0] ewb, input logic ewe,
                               input logic [63:0] ecnt);
      vec_t v;
      v.memtoreg = m2r;  v.regwrite = rw;  v.rd = d;
      v.read_data = ld;  v.result = alu;   v.rs1 = a1;  v.rs2 = a2;
      v.exp_rd1 = e1;    v.exp_rd2 = e2;   v.exp_wb = ewb;
      v.exp_we = ewe;    v.exp_cnt = ecnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idle64();
      regwrite = 1'b0; memtoreg = 1'b0; rd = 5'd0;
      read_data = '0;  result = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;

      // Vectors applied after a clean reset; expectations are pre-edge values.
      vecs[0] = mk(0, 1, 5'd5,  64'h1111, 64'h0000_0000_DEAD_BEEF, 5'd5,  5'd0,
                   64'hDEAD_BEEF, 64'h0, 64'hDEAD_BEEF, 1, 64'd0);
      vecs[1] = mk(0, 0, 5'd5,  64'h0, 64'h0, 5'd5,  5'd6,
                   64'hDEAD_BEEF, 64'h0, 64'h0, 0, 64'd1);
      vecs[2] = mk(1, 1, 5'd7,  64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 5'd7,
                   64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
                   64'h1234_5678_9ABC_DEF0, 1, 64'd1);
      vecs[3] = mk(0, 0, 5'd0,  64'h0, 64'h0, 5'd7,  5'd5,
                   64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF, 64'h0, 0, 64'd2);
      vecs[4] = mk(0, 1, 5'd0,  64'h0, 64'hFF, 5'd0,  5'd0,
                   64'h0, 64'h0, 64'hFF, 0, 64'd2);
      vecs[5] = mk(0, 0, 5'd0,  64'h0, 64'h0, 5'd0,  5'd7,
                   64'h0, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, 64'd2);
      vecs[6] = mk(0, 1, 5'd5,  64'h77, 64'hCAFE, 5'd5, 5'd7,
                   64'hCAFE, 64'h1234_5678_9ABC_DEF0, 64'hCAFE, 1, 64'd2);
      vecs[7] = mk(1, 1, 5'd31, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 5'd31, 5'd5,
                   64'hA5A5_A5A5_A5A5_A5A5, 64'hCAFE, 64'hA5A5_A5A5_A5A5_A5A5, 1, 64'd3);
      vecs[8] = mk(0, 0, 5'd31, 64'h0, 64'h0, 5'd31, 5'd30,
                   64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 64'h0, 0, 64'd4);

      reset = 1'b1;
      idle64();
      rs1 = 5'd0; rs2 = 5'd0;
      regwrite_8 = 1'b0; memtoreg_8 = 1'b0; rd_8 = 5'd0;
      read_data_8 = '0; result_8 = '0; rs1_8 = 5'd0; rs2_8 = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state: every register reads zero on both ports.
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         #1;
         check($sformatf("reset_rd1_r%0d", i), readdata1, 64'h0);
         check($sformatf("reset_rd2_r%0d", 31 - i), readdata2, 64'h0);
      end
      check("reset_count", retire_count, 64'h0);

      // Table-driven vectors through the scoreboard.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         memtoreg  = vecs[i].memtoreg;
         regwrite  = vecs[i].regwrite;
         rd        = vecs[i].rd;
         read_data = vecs[i].read_data;
         result    = vecs[i].result;
         rs1       = vecs[i].rs1;
         rs2       = vecs[i].rs2;
         e.rd1 = vecs[i].exp_rd1;
         e.rd2 = vecs[i].exp_rd2;
         e.wb  = vecs[i].exp_wb;
         e.we  = vecs[i].exp_we;
         e.cnt = vecs[i].exp_cnt;
         sb.push_back(e);
         #1;
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_empty_v%0d actual=0 expected=1", i);
         end else begin
            e = sb.pop_front();
            check($sformatf("v%0d_readdata1", i), readdata1, e.rd1);
            check($sformatf("v%0d_readdata2", i), readdata2, e.rd2);
            check($sformatf("v%0d_wb_data", i), wb_data, e.wb);
            check($sformatf("v%0d_wb_we", i), {63'b0, wb_we}, {63'b0, e.we});
            check($sformatf("v%0d_retire_count", i), retire_count, e.cnt);
         end
      end

      // Asynchronous reset in the middle of a cycle with a write pending.
      @(negedge clk);
      idle64();
      regwrite = 1'b1; rd = 5'd3; result = 64'hAA;
      @(negedge clk);
      regwrite = 1'b1; rd = 5'd4; result = 64'hBB;
      rs1 = 5'd3; rs2 = 5'd4;
      #1;
      check("prerst_reg3", readdata1, 64'hAA);
      check("prerst_count", retire_count, 64'd5);
      #1;
      reset = 1'b1;
      #1;
      check("rst_reg3_cleared", readdata1, 64'h0);
      check("rst_reg4_bypass", readdata2, 64'hBB);
      check("rst_count_cleared", retire_count, 64'h0);
      @(posedge clk);
      @(negedge clk);
      idle64();
      reset = 1'b0;
      rs1 = 5'd4; rs2 = 5'd3;
      #1;
      check("postrst_reg4_not_written", readdata1, 64'h0);
      check("postrst_reg3", readdata2, 64'h0);
      rs1 = 5'd7; rs2 = 5'd31;
      #1;
      check("postrst_reg7", readdata1, 64'h0);
      check("postrst_reg31", readdata2, 64'h0);
      check("postrst_count", retire_count, 64'h0);

      // First write after reset release lands on the next edge.
      @(negedge clk);
      regwrite = 1'b1; memtoreg = 1'b1; rd = 5'd9; read_data = 64'h99; result = 64'h55;
      @(negedge clk);
      idle64();
      rs1 = 5'd9;
      #1;
      check("first_write_reg9", readdata1, 64'h99);
      check("first_write_count", retire_count, 64'd1);

      // Counter wrap on the 8-bit build: 255 writes, then one more.
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         regwrite_8 = 1'b1;
         rd_8       = 5'((i % 31) + 1);
         result_8   = 8'(i);
      end
      @(negedge clk);
      regwrite_8 = 1'b0;
      rs1_8 = 5'd7;
      #1;
      check("wrap_count_255", {56'b0, retire_count_8}, 64'd255);
      check("wrap_last_reg7", {56'b0, readdata1_8}, 64'hFE);
      @(negedge clk);
      regwrite_8 = 1'b1; rd_8 = 5'd1; result_8 = 8'h3C;
      @(negedge clk);
      regwrite_8 = 1'b0;
      #1;
      check("wrap_count_0", {56'b0, retire_count_8}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
